iseq_arbiter: RTL and testbench

Owns the command-issue resource behind `iseq_dispatcher`, sharing it between three requesters: host instruction sequences, periodic-read calibration, and auto-refresh. Only one requester owns the resource at a time. The arbiter is the only source of `process_iseq` and `periodic_read_lock`, and it grants ownership only when the dispatcher is idle. Priority is auto-refresh first, then host and periodic read alternating round-robin. An owner is never preempted.

---
 rtl/iseq_arbiter.sv | 174 +++++++++++++++++
 tb/tb_iseq_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iseq_arbiter.sv
// Arbitrates the dispatcher's command-issue resource between host sequences, periodic read and auto-refresh.
// Optional host-run watchdog is compiled in with `define ISEQ_ARB_WATCHDOG_EN.
module iseq_arbiter #(
  parameter int unsigned WDOG_CYCLES = 1048576,
  parameter int unsigned DEFER_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   host_req,
  output logic                   host_ack,
  output logic                   host_done,
  input  logic                   pr_req,
  output logic                   pr_ack,
  input  logic                   pr_done,
  input  logic                   aref_req,
  output logic                   aref_ack,
  input  logic                   aref_done,
  output logic                   process_iseq,
  input  logic                   dispatcher_busy,
  output logic                   periodic_read_lock,
  output logic                   aref_lock,
  output logic [1:0]             owner,
  output logic [DEFER_WIDTH-1:0] aref_defer_cnt,
  output logic                   wdog_err
);

  localparam int unsigned WDOG_W = 21;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_HOST = 2'd1;
  localparam logic [1:0] OWN_PR   = 2'd2;
  localparam logic [1:0] OWN_AREF = 2'd3;

  localparam logic RR_HOST = 1'b0;
  localparam logic RR_PR   = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_H_START,
    S_H_WAIT,
    S_H_RUN,
    S_PR,
    S_AREF
  } state_t;

  state_t state;
  logic   last_rr;
  logic   holdoff;
  logic   wdog_fire;

  if (WDOG_CYCLES == 0 || WDOG_CYCLES >= (1 << WDOG_W)) begin : g_wdog_range
    $error("iseq_arbiter: WDOG_CYCLES must be in 1 .. 2**21-1");
  end

`ifdef ISEQ_ARB_WATCHDOG_EN
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_CYCLES);

  logic [WDOG_W-1:0] wdog_cnt;

  // Loaded with 2 on leaving H_START so the count equals cycles since the host grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (state == S_H_START) begin
        wdog_cnt <= WDOG_W'(2);
      end else if ((state == S_H_WAIT || state == S_H_RUN) && !wdog_fire) begin
        wdog_cnt <= wdog_cnt + WDOG_W'(1);
      end
      if (wdog_fire) begin
        wdog_err <= 1'b1;
      end
    end
  end

  assign wdog_fire = (state == S_H_WAIT || state == S_H_RUN) && (wdog_cnt >= WDOG_LIMIT);
`else
  assign wdog_fire = 1'b0;
  assign wdog_err  = 1'b0;
`endif

  // Arbitration FSM; holdoff guarantees one idle cycle between release and the next grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      last_rr            <= RR_HOST;
      holdoff            <= 1'b0;
      process_iseq       <= 1'b0;
      host_ack           <= 1'b0;
      host_done          <= 1'b0;
      pr_ack             <= 1'b0;
      aref_ack           <= 1'b0;
      periodic_read_lock <= 1'b0;
      aref_lock          <= 1'b0;
      owner              <= OWN_NONE;
      aref_defer_cnt     <= '0;
    end else begin
      process_iseq <= 1'b0;
      host_ack     <= 1'b0;
      host_done    <= 1'b0;
      pr_ack       <= 1'b0;
      aref_ack     <= 1'b0;
      holdoff      <= 1'b0;

      if (aref_req && state != S_AREF && aref_defer_cnt != '1) begin
        aref_defer_cnt <= aref_defer_cnt + DEFER_WIDTH'(1);
      end

      case (state)
        S_IDLE: begin
          if (!holdoff && !dispatcher_busy) begin
            if (aref_req) begin
              state          <= S_AREF;
              aref_ack       <= 1'b1;
              aref_lock      <= 1'b1;
              owner          <= OWN_AREF;
              aref_defer_cnt <= '0;
            end else if (pr_req && (!host_req || last_rr == RR_HOST)) begin
              state              <= S_PR;
              pr_ack             <= 1'b1;
              periodic_read_lock <= 1'b1;
              owner              <= OWN_PR;
            end else if (host_req) begin
              state        <= S_H_START;
              process_iseq <= 1'b1;
              host_ack     <= 1'b1;
              owner        <= OWN_HOST;
            end
          end
        end
        S_H_START: begin
          state <= S_H_WAIT;
        end
        // Busy still low one cycle after the start pulse means the FIFOs were empty.
        S_H_WAIT, S_H_RUN: begin
          if (wdog_fire || !dispatcher_busy) begin
            state     <= S_IDLE;
            host_done <= 1'b1;
            owner     <= OWN_NONE;
            holdoff   <= 1'b1;
            if (state == S_H_RUN) begin
              last_rr <= RR_HOST;
            end
          end else begin
            state <= S_H_RUN;
          end
        end
        S_PR: begin
          if (pr_done) begin
            state              <= S_IDLE;
            periodic_read_lock <= 1'b0;
            owner              <= OWN_NONE;
            last_rr            <= RR_PR;
            holdoff            <= 1'b1;
          end
        end
        S_AREF: begin
          if (aref_done) begin
            state     <= S_IDLE;
            aref_lock <= 1'b0;
            owner     <= OWN_NONE;
            holdoff   <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          owner <= OWN_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iseq_arbiter.sv
// Self-checking bench for iseq_arbiter: per-cycle vector table plus scripted multi-cycle sequences.
module tb_iseq_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_req, host_ack, host_done;
  logic        pr_req, pr_ack, pr_done;
  logic        aref_req, aref_ack, aref_done;
  logic        process_iseq, dispatcher_busy;
  logic        periodic_read_lock, aref_lock;
  logic [1:0]  owner;
  logic [15:0] aref_defer_cnt;
  logic        wdog_err;

  iseq_arbiter #(
    .WDOG_CYCLES(64),
    .DEFER_WIDTH(16)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .host_req           (host_req),
    .host_ack           (host_ack),
    .host_done          (host_done),
    .pr_req             (pr_req),
    .pr_ack             (pr_ack),
    .pr_done            (pr_done),
    .aref_req           (aref_req),
    .aref_ack           (aref_ack),
    .aref_done          (aref_done),
    .process_iseq       (process_iseq),
    .dispatcher_busy    (dispatcher_busy),
    .periodic_read_lock (periodic_read_lock),
    .aref_lock          (aref_lock),
    .owner              (owner),
    .aref_defer_cnt     (aref_defer_cnt),
    .wdog_err           (wdog_err)
  );

  always #5 clk = ~clk;

  // in  = {host_req, pr_req, pr_done, aref_req, aref_done, dispatcher_busy} for one cycle
  // exp = {process_iseq, host_ack, host_done, pr_ack, aref_ack, pr_lock, aref_lock, owner} next cycle
  typedef struct packed {
    logic [5:0] in;
    logic [8:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [8:0] exp_q[$];
  int         own_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Environment models (dispatcher busy, PR/AREF completion, host dropping its request).
  bit model_en  = 1'b0;
  bit host_drop = 1'b0;
  bit pi_pend   = 1'b0;
  int run_len   = 0;
  int busy_left = 0;
  int pr_lat    = 0;
  int ar_lat    = 0;
  int pd_at     = -1;
  int ad_at     = -1;

  function automatic logic [8:0] obs();
    return {process_iseq, host_ack, host_done, pr_ack, aref_ack,
            periodic_read_lock, aref_lock, owner};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (model_en) begin
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) dispatcher_busy = 1'b0;
      end
      if (pi_pend) begin
        pi_pend = 1'b0;
        if (run_len > 0) begin
          dispatcher_busy = 1'b1;
          busy_left       = run_len;
        end
      end
      if (process_iseq) pi_pend = 1'b1;
      if (host_ack && host_drop) host_req = 1'b0;
      if (pr_ack && pr_lat > 0) pd_at = cyc + pr_lat;
      pr_done = (cyc == pd_at);
      if (aref_ack) begin
        aref_req = 1'b0;
        if (ar_lat > 0) ad_at = cyc + ar_lat;
      end
      aref_done = (cyc == ad_at);
    end
  endtask

  task automatic clear_inputs();
    host_req = 1'b0; pr_req = 1'b0; pr_done = 1'b0;
    aref_req = 1'b0; aref_done = 1'b0; dispatcher_busy = 1'b0;
    pi_pend = 1'b0; busy_left = 0; pd_at = -1; ad_at = -1;
  endtask

  // Leaves the bench just after an edge with reset released; the next cycle is cycle 0.
  task automatic do_reset();
    model_en = 1'b0;
    rst_n    = 1'b0;
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    int ha_cyc, hd_cyc, pi_cyc, aa_cyc, own1, own3_early, grants, got;
    int lock_bad, lock_cyc, defer_prev, defer_grant, defer_after, n_ack, m;
    logic [8:0] e;

    vecs.push_back({6'b100000, 9'b1100000_01}); // host grant
    vecs.push_back({6'b000000, 9'b0000000_01});
    vecs.push_back({6'b000001, 9'b0000000_01});
    vecs.push_back({6'b000001, 9'b0000000_01});
    vecs.push_back({6'b000000, 9'b0010000_00}); // busy fell: host_done
    vecs.push_back({6'b010000, 9'b0000000_00}); // mandatory idle cycle
    vecs.push_back({6'b010000, 9'b0001010_10}); // PR grant
    vecs.push_back({6'b010000, 9'b0000010_10});
    vecs.push_back({6'b001000, 9'b0000000_00}); // pr_done
    vecs.push_back({6'b000110, 9'b0000000_00}); // stray aref_done in IDLE
    vecs.push_back({6'b000100, 9'b0000101_11}); // AREF grant
    vecs.push_back({6'b001000, 9'b0000001_11}); // stray pr_done in AREF
    vecs.push_back({6'b000010, 9'b0000000_00}); // aref_done
    vecs.push_back({6'b110000, 9'b0000000_00});
    vecs.push_back({6'b110000, 9'b1100000_01}); // tie after PR: host wins
    vecs.push_back({6'b010000, 9'b0000000_01});
    vecs.push_back({6'b010000, 9'b0010000_00}); // empty FIFOs: done 2 cycles after ack
    vecs.push_back({6'b000000, 9'b0000000_00});
    vecs.push_back({6'b110001, 9'b0000000_00}); // dispatcher busy blocks grant
    vecs.push_back({6'b000000, 9'b0000000_00}); // requests dropped: nothing latched
    vecs.push_back({6'b000000, 9'b0000000_00});
    vecs.push_back({6'b110100, 9'b0000101_11}); // AREF beats everyone
    vecs.push_back({6'b110010, 9'b0000000_00});
    vecs.push_back({6'b110000, 9'b0000000_00});
    vecs.push_back({6'b110000, 9'b1100000_01}); // last_rr still PR after empty host run

    // Reset state
    do_reset();
    chk("reset outputs", int'(obs()), 0);
    chk("reset defer_cnt", int'(aref_defer_cnt), 0);
    chk("reset wdog_err", int'(wdog_err), 0);

    // Vector table
    foreach (vecs[i]) begin
      {host_req, pr_req, pr_done, aref_req, aref_done, dispatcher_busy} = vecs[i].in;
      exp_q.push_back(vecs[i].exp);
      step();
      e = exp_q.pop_front();
      chk($sformatf("vec %0d outputs", i), int'(obs()), int'(e));
    end

    // Single host run with 10 busy cycles
    do_reset();
    model_en = 1'b1; run_len = 10; host_drop = 1'b1; host_req = 1'b1;
    ha_cyc = -1; hd_cyc = -1; pi_cyc = -1; own1 = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (host_ack && ha_cyc < 0) ha_cyc = cyc;
      if (process_iseq && pi_cyc < 0) pi_cyc = cyc;
      if (host_done && hd_cyc < 0) hd_cyc = cyc;
      if (owner == 2'd1) own1++;
    end
    chk("host1 host_ack cycle", ha_cyc, 1);
    chk("host1 process_iseq cycle", pi_cyc, 1);
    chk("host1 host_done cycle", hd_cyc, 13);
    chk("host1 owner=host cycles", own1, 12);
    chk("host1 final owner", int'(owner), 0);
`ifndef ISEQ_ARB_WATCHDOG_EN
    chk("host1 wdog_err tied low", int'(wdog_err), 0);
`endif

    // PR/host round-robin with both requests held
    do_reset();
    model_en = 1'b1; run_len = 4; host_drop = 1'b0; pr_lat = 5;
    host_req = 1'b1; pr_req = 1'b1;
    own_q = '{2, 1, 2, 1};
    grants = 0; lock_bad = 0; lock_cyc = 0;
    for (int i = 0; i < 200 && grants < 4; i++) begin
      step();
      if (periodic_read_lock != (owner == 2'd2)) lock_bad++;
      if (periodic_read_lock) lock_cyc++;
      if (pr_ack || host_ack) begin
        got = pr_ack ? 2 : 1;
        if (own_q.size() > 0) chk($sformatf("rr grant %0d", grants), got, own_q.pop_front());
        grants++;
      end
    end
    host_req = 1'b0; pr_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (periodic_read_lock != (owner == 2'd2)) lock_bad++;
      if (periodic_read_lock) lock_cyc++;
    end
    chk("rr grant count", grants, 4);
    chk("rr lock vs owner", lock_bad, 0);
    chk("rr lock cycles", lock_cyc, 12);
    chk("rr final owner", int'(owner), 0);

    // Refresh arriving during a 20-cycle host run
    do_reset();
    model_en = 1'b1; run_len = 20; host_drop = 1'b1; ar_lat = 3; pr_lat = 0;
    host_req = 1'b1;
    hd_cyc = -1; aa_cyc = -1; own3_early = 0; defer_prev = 0; defer_grant = -1; defer_after = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (cyc == 6) aref_req = 1'b1;
      if (host_done && hd_cyc < 0) hd_cyc = cyc;
      if (owner == 2'd3 && hd_cyc < 0) own3_early++;
      if (aref_ack && aa_cyc < 0) begin
        aa_cyc      = cyc;
        defer_grant = defer_prev;
        defer_after = int'(aref_defer_cnt);
        chk("aref lock at ack", int'(aref_lock), 1);
      end
      defer_prev = int'(aref_defer_cnt);
    end
    chk("aref host_done cycle", hd_cyc, 23);
    chk("aref no preemption", own3_early, 0);
    chk("aref ack cycle", aa_cyc, 25);
    chk("aref defer at grant", defer_grant, 18);
    chk("aref defer after grant", defer_after, 0);
    chk("aref final owner", int'(owner), 0);

    // Reset while PR owns the resource
    do_reset();
    model_en = 1'b1; pr_lat = 0; ar_lat = 0;
    pr_req = 1'b1;
    for (int i = 0; i < 10 && !periodic_read_lock; i++) step();
    chk("rstpr lock before reset", int'(periodic_read_lock), 1);
    model_en = 1'b0;
    rst_n = 1'b0; pr_req = 1'b0; pr_done = 1'b1;
    step();
    chk("rstpr outputs in reset", int'(obs()), 0);
    chk("rstpr defer in reset", int'(aref_defer_cnt), 0);
    rst_n = 1'b1;
    step();
    chk("rstpr stray pr_done", int'(obs()), 0);
    pr_done = 1'b0; pr_req = 1'b1; host_req = 1'b1;
    step();
    chk("rstpr tie after reset goes to PR", int'(obs()), int'(9'b0001010_10));
    pr_req = 1'b0; host_req = 1'b0;

`ifdef ISEQ_ARB_WATCHDOG_EN
    // Watchdog: busy never drops
    do_reset();
    model_en = 1'b1; run_len = 100000; host_drop = 1'b1; pr_lat = 0; ar_lat = 0;
    host_req = 1'b1;
    hd_cyc = -1;
    for (int i = 0; i < 200 && hd_cyc < 0; i++) begin
      step();
      if (host_done) hd_cyc = cyc;
    end
    chk("wdog host_done cycle", hd_cyc, 65);
    chk("wdog err set", int'(wdog_err), 1);
    host_req = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (host_ack) n_ack++;
    end
    chk("wdog no grant while busy", n_ack, 0);
    dispatcher_busy = 1'b0; busy_left = 0;
    m = cyc; ha_cyc = -1;
    for (int i = 0; i < 10 && ha_cyc < 0; i++) begin
      step();
      if (host_ack) ha_cyc = cyc;
    end
    chk("wdog regrant after busy drops", ha_cyc, m + 1);
    chk("wdog err sticky", int'(wdog_err), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
